// File: rtl/write_data_arbiter_pkg.sv
// Shared types, widths and helpers for the write-data arbiter.
package write_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int unsigned CNT_WIDTH = 16;

    // Round-robin pointer advance, wrapping at num_ch.
    function automatic logic [31:0] ptr_inc(input logic [31:0] idx, input logic [31:0] num_ch);
        return ((idx + 32'd1) >= num_ch) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/write_data_arbiter_if.sv
// Producer-side request bus and memory-buffer write port of the arbiter.
interface write_data_arbiter_if
    import write_arb_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
);
    localparam int unsigned IDX_W = $clog2(NUM_CH);

    arb_mode_e                      arb_mode_i;
    logic [NUM_CH-1:0]              ch_valid_i;
    logic [NUM_CH*DATA_WIDTH-1:0]   ch_data_i;
    logic [NUM_CH*ADDR_WIDTH-1:0]   ch_addr_i;
    logic [NUM_CH-1:0]              ch_ready_o;
    logic                           write_valid_o;
    logic [DATA_WIDTH-1:0]          write_data_o;
    logic [ADDR_WIDTH-1:0]          write_addr_o;
    logic                           write_ready_i;
    logic [IDX_W-1:0]               grant_ch_o;
    logic [CNT_WIDTH-1:0]           xfer_count_o;

    // Environment side: producers and memory buffer.
    modport master (
        output arb_mode_i, ch_valid_i, ch_data_i, ch_addr_i, write_ready_i,
        input  ch_ready_o, write_valid_o, write_data_o, write_addr_o, grant_ch_o, xfer_count_o
    );

    // Arbiter side.
    modport slave (
        input  arb_mode_i, ch_valid_i, ch_data_i, ch_addr_i, write_ready_i,
        output ch_ready_o, write_valid_o, write_data_o, write_addr_o, grant_ch_o, xfer_count_o
    );

endinterface

// File: rtl/write_data_arbiter_rr.sv
// Combinational fixed-priority / round-robin request arbiter.
module rr_arbiter
    import write_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    localparam int unsigned IDX_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    input  arb_mode_e         mode_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [IDX_W-1:0]  gnt_idx_o,
    output logic              any_gnt_o
);

    logic [31:0] start;
    logic [31:0] pos;

    // Scan from the farthest position back to the start so the first
    // requester at or after the start position is the last one written.
    always_comb begin
        start     = (mode_i == ARB_RR) ? 32'(ptr_i) : 32'd0;
        pos       = 32'd0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
            pos = start + 32'(k);
            if (pos >= NUM_CH) begin
                pos = pos - NUM_CH;
            end
            if (req_i[IDX_W'(pos)]) begin
                gnt_idx_o = IDX_W'(pos);
                any_gnt_o = 1'b1;
            end
        end
    end

    // One-hot form of the winning index.
    assign gnt_o = any_gnt_o ? (NUM_CH'(1) << gnt_idx_o) : '0;

endmodule

// File: rtl/write_data_arbiter.sv
// Arbitrates NUM_CH producer channels onto one registered write port.
module write_data_arbiter
    import write_arb_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    write_data_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_CH);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      ptr_q,   ptr_d;
    logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;

    logic [NUM_CH-1:0]     gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  any_gnt;
    logic                  load_c;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req_i     (bus.ch_valid_i),
        .ptr_i     (ptr_q),
        .mode_i    (bus.arb_mode_i),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_gnt_o (any_gnt)
    );

    // Output register may take a new write when empty or being drained.
    assign load_c = !valid_q || bus.write_ready_i;

    // Accept only the winner, and never while in reset or stalled.
    assign bus.ch_ready_o = (load_c && !rst) ? gnt : '0;

    // Next-state: load winner, drop valid when idle, count completed writes.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = (valid_q && bus.write_ready_i) ? (cnt_q + CNT_WIDTH'(1)) : cnt_q;
        if (load_c) begin
            valid_d = any_gnt;
            if (any_gnt) begin
                data_d  = bus.ch_data_i[gnt_idx * DATA_WIDTH +: DATA_WIDTH];
                addr_d  = bus.ch_addr_i[gnt_idx * ADDR_WIDTH +: ADDR_WIDTH];
                grant_d = gnt_idx;
                if (bus.arb_mode_i == ARB_RR) begin
                    ptr_d = IDX_W'(ptr_inc(32'(gnt_idx), 32'(NUM_CH)));
                end
            end
        end
    end

    // State registers; reset discards any held write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.write_valid_o = valid_q;
    assign bus.write_data_o  = data_q;
    assign bus.write_addr_o  = addr_q;
    assign bus.grant_ch_o    = grant_q;
    assign bus.xfer_count_o  = cnt_q;

endmodule

// File: tb/tb_write_data_arbiter.sv
// Scoreboard bench for write_data_arbiter with a queue-based reference model.
module tb_write_data_arbiter;
    import write_arb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        int            g;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    write_data_arbiter_if #(.NUM_CH(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    write_data_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;

    // Reference model state: is a write held, RR pointer, completed count.
    bit   m_valid = 1'b0;
    int   m_ptr   = 0;
    int   m_cnt   = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ptr   = 0;
        m_cnt   = 0;
        exp_q.delete();
    endtask

    // Model: at mid-cycle, predict who is accepted and what the next edge loads.
    always @(negedge clk) begin
        if (rst) begin
            chk("ch_ready_in_reset", 32'(bus.ch_ready_o), 32'd0);
        end else begin
            bit   load;
            int   win;
            int   start;
            exp_t e;
            load  = !m_valid || bus.write_ready_i;
            win   = -1;
            start = (bus.arb_mode_i == ARB_RR) ? m_ptr : 0;
            if (load) begin
                for (int k = 0; k < int'(N); k++) begin
                    if (bus.ch_valid_i[(start + k) % N]) begin
                        win = (start + k) % N;
                        break;
                    end
                end
            end
            chk("ch_ready", 32'(bus.ch_ready_o), (win >= 0) ? (32'd1 << win) : 32'd0);
            if (m_valid && bus.write_ready_i) m_cnt = (m_cnt + 1) % 65536;
            if (load) begin
                if (win >= 0) begin
                    e.d = bus.ch_data_i[win*DW +: DW];
                    e.a = bus.ch_addr_i[win*AW +: AW];
                    e.g = win;
                    exp_q.push_back(e);
                    m_valid = 1'b1;
                    if (bus.arb_mode_i == ARB_RR) m_ptr = (win + 1) % N;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: compare the output register against the scoreboard each cycle.
    always begin
        @(posedge clk);
        #3;
        if (rst) begin
            chk("rst_write_valid", 32'(bus.write_valid_o), 32'd0);
            chk("rst_xfer_count",  32'(bus.xfer_count_o),  32'd0);
            chk("rst_write_data",  32'(bus.write_data_o),  32'd0);
            chk("rst_grant_ch",    32'(bus.grant_ch_o),    32'd0);
        end else begin
            chk("write_valid", 32'(bus.write_valid_o), 32'(m_valid));
            chk("xfer_count",  32'(bus.xfer_count_o),  32'(m_cnt));
            if (bus.write_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got write_valid=1 expected no pending write at %0t", $time);
                end else begin
                    chk("write_data", 32'(bus.write_data_o), 32'(exp_q[0].d));
                    chk("write_addr", 32'(bus.write_addr_o), 32'(exp_q[0].a));
                    chk("grant_ch",   32'(bus.grant_ch_o),   32'(exp_q[0].g));
                    if (bus.write_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic [N-1:0] v, input logic m, input logic r);
        @(posedge clk);
        #1;
        bus.ch_valid_i    = v;
        bus.arb_mode_i    = arb_mode_e'(m);
        bus.write_ready_i = r;
    endtask

    task automatic set_ch(input int ch, input logic [DW-1:0] d, input logic [AW-1:0] a);
        bus.ch_data_i[ch*DW +: DW] = d;
        bus.ch_addr_i[ch*AW +: AW] = a;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_valid", 32'(bus.write_valid_o), 32'd0);
        chk("async_rst_count", 32'(bus.xfer_count_o),  32'd0);
        chk("async_rst_grant", 32'(bus.grant_ch_o),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.ch_valid_i    = '0;
        bus.write_ready_i = 1'b1;
    endtask

    initial begin
        int hits[N];
        bus.arb_mode_i    = ARB_FIXED;
        bus.ch_valid_i    = '0;
        bus.ch_data_i     = '0;
        bus.ch_addr_i     = '0;
        bus.write_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset while a write is held under backpressure.
        set_ch(0, 16'hA5A5, 8'h5A);
        repeat (3) step(4'b0001, 1'b0, 1'b0);
        #1;
        chk("hold_data",  32'(bus.write_data_o),  32'h0000_A5A5);
        chk("hold_valid", 32'(bus.write_valid_o), 32'd1);
        do_reset();

        // Fixed priority: channel 0 always wins over channel 1.
        set_ch(0, 16'h1111, 8'h10);
        set_ch(1, 16'h2222, 8'h20);
        for (int i = 0; i < 4; i++) begin
            step(4'b0011, 1'b0, 1'b1);
            #1;
            chk("fixed_ch_ready", 32'(bus.ch_ready_o), 32'b0001);
            if (i > 0) chk("fixed_data", 32'(bus.write_data_o), 32'h0000_1111);
        end
        step(4'b0000, 1'b0, 1'b1);
        #1;
        chk("fixed_last_data", 32'(bus.write_data_o), 32'h0000_1111);
        step(4'b0000, 1'b0, 1'b1);
        #1;
        chk("fixed_count", 32'(bus.xfer_count_o), 32'd4);

        // Round-robin with all channels requesting.
        for (int c = 0; c < int'(N); c++) begin
            hits[c] = 0;
            set_ch(c, DW'(16'h3000 + c), AW'(8'h30 + c));
        end
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 1'b1, 1'b1);
            #1;
            chk("rr_ch_ready", 32'(bus.ch_ready_o), 32'd1 << (i % 4));
            if (i > 0) chk("rr_grant_ch", 32'(bus.grant_ch_o), 32'((i - 1) % 4));
            for (int c = 0; c < int'(N); c++) hits[c] += int'(bus.ch_ready_o[c]);
        end
        for (int c = 0; c < int'(N); c++) chk("rr_hits", 32'(hits[c]), 32'd2);
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);

        // Backpressure: held write frozen, next winner loads on release.
        set_ch(0, 16'hBEEF, 8'h12);
        set_ch(1, 16'hCAFE, 8'h34);
        step(4'b0011, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b0011, 1'b1, 1'b0);
            #1;
            chk("bp_data",     32'(bus.write_data_o), 32'h0000_BEEF);
            chk("bp_addr",     32'(bus.write_addr_o), 32'h12);
            chk("bp_ch_ready", 32'(bus.ch_ready_o),   32'd0);
        end
        step(4'b0011, 1'b1, 1'b1);
        #1;
        chk("bp_release_ready", 32'(bus.ch_ready_o), 32'b0010);
        step(4'b0000, 1'b1, 1'b1);
        #1;
        chk("bp_next_data", 32'(bus.write_data_o), 32'h0000_CAFE);

        // Mode switch: RR grants 2, fixed grants 2 with ptr held, RR then grants 3.
        step(4'b1111, 1'b1, 1'b1);
        #1;
        chk("ms_rr_first", 32'(bus.ch_ready_o), 32'b0100);
        step(4'b1100, 1'b0, 1'b1);
        #1;
        chk("ms_fixed", 32'(bus.ch_ready_o), 32'b0100);
        step(4'b1111, 1'b1, 1'b1);
        #1;
        chk("ms_rr_after", 32'(bus.ch_ready_o), 32'b1000);
        step(4'b0000, 1'b1, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < int'(N); c++) set_ch(c, DW'($urandom), AW'($urandom));
            step(N'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);

        // Counter wrap after 65535 back-to-back writes.
        do_reset();
        set_ch(0, 16'h0F0F, 8'hF0);
        for (int k = 1; k <= 65538; k++) begin
            step(4'b0001, 1'b0, 1'b1);
            if (k == 65537) begin
                #1;
                chk("wrap_ffff", 32'(bus.xfer_count_o), 32'h0000_FFFF);
            end else if (k == 65538) begin
                #1;
                chk("wrap_zero",  32'(bus.xfer_count_o),  32'd0);
                chk("wrap_valid", 32'(bus.write_valid_o), 32'd1);
            end
        end
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_data_arbiter.md
# write_data_arbiter

Parametrised successor to the two-input write-data select: arbitrates NUM_CH producer channels onto the single write port of the memory buffer. Selection is by fixed-priority or round-robin arbitration instead of an external select line. A registered output stage provides a valid/ready handshake toward the buffer. A wrapping transfer counter supports debug.

## Interface
- NUM_CH, 2: number of producer channels; legal range 2..16.
- DATA_WIDTH, 16: width of each channel's write data.
- ADDR_WIDTH, 8: width of each channel's write address.
- Clk  in  1  single clock; all state on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Arb_Mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- Ch_Valid  in  NUM_CH  per-channel write request.
- Ch_Data  in  NUM_CH*DATA_WIDTH  flat packed data; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- Ch_Addr  in  NUM_CH*ADDR_WIDTH  flat packed address; same packing.
- Ch_Ready  out  NUM_CH  one-hot-or-zero accept; a transfer occurs when Ch_Valid[i] & Ch_Ready[i].
- Write_Valid  out  1  output register holds a write.
- Write_Data  out  DATA_WIDTH  registered data to memory buffer.
- Write_Addr  out  ADDR_WIDTH  registered address to memory buffer.
- Write_Ready  in  1  memory buffer accepts the write this cycle.
- Grant_Ch  out  $clog2(NUM_CH)  index of the channel whose data sits in the output register.
- Xfer_Count  out  16  completed writes (Write_Valid & Write_Ready); wraps modulo 2^16.

## Operation
- Load enable: Load = !Write_Valid | Write_Ready. Arbitration proceeds only when Load is high.
- Ch_Ready is combinational: one-hot of the winning channel when Load is high and any Ch_Valid is set. Otherwise Ch_Ready is all zero.
- Ch_Ready must never depend on Ch_Valid of the same channel only. A winner is asserted only if that channel is valid.
- Fixed mode: the winner is the lowest index with Ch_Valid set. The round-robin pointer is held.
- Round-robin mode: search starts at pointer Rr_Ptr and wraps upward modulo NUM_CH. On each grant, Rr_Ptr <= (winner + 1) mod NUM_CH.
- On grant: Write_Data, Write_Addr and Grant_Ch load from the winner, and Write_Valid <= 1.
- On Load with no valid channel: Write_Valid <= 0. Data and address registers hold their previous values.
- While Write_Valid & !Write_Ready: outputs are frozen, Ch_Ready = 0, and Rr_Ptr holds.
- Xfer_Count increments on each Write_Valid & Write_Ready; 0xFFFF -> 0x0000.
- Arb_Mode is sampled combinationally each arbitration cycle. A change takes effect on the next grant, and Rr_Ptr is not reset.

## Timing
- Reset (asynchronous, immediate): Write_Valid=0, Write_Data=0, Write_Addr=0, Grant_Ch=0, Rr_Ptr=0, Xfer_Count=0.
- A held write is discarded on reset mid-operation.
- Ch_Ready is 0 while Rst is high.
- Latency: Ch transfer in cycle N -> Write_Valid with that data in cycle N+1.
- Throughput: one write per cycle while Write_Ready is held high and requests are present. There are no bubbles.
- Simultaneous drain and load: Write_Ready high with a pending request replaces the register contents in the same edge. Xfer_Count increments, and Write_Valid stays 1.
- All channels valid in round-robin mode: grants rotate 0,1,...,NUM_CH-1,0 on consecutive accepting cycles.
- Single requester: it is granted every accepting cycle regardless of Rr_Ptr.

## Structure
- Package write_arb_pkg holds:
  - typedef arb_mode_e (ARB_FIXED=1'b0, ARB_RR=1'b1).
  - Localparam CNT_WIDTH=16.
  - A function for the wrapped pointer increment.
- Sub-module rr_arbiter: purely combinational.
  - Inputs: request vector, pointer, mode.
  - Outputs: one-hot grant, grant index, any_grant.
  - Parametrised by NUM_CH.
- The top level holds the output register, Rr_Ptr and Xfer_Count.

## Test plan
- Reset mid-hold: Ch_Valid=01 with Ch_Data[0]=16'hA5A5, Write_Ready=0 for 3 cycles, then pulse Rst. Required: Write_Valid drops immediately, Xfer_Count=0, and Grant_Ch=0.
- Fixed priority, NUM_CH=2, Write_Ready=1, Arb_Mode=0, Ch_Valid=11 for 4 cycles, with Ch_Data[0]=16'h1111 and Ch_Data[1]=16'h2222. Required: Write_Data=16'h1111 four times, Ch_Ready=01 each cycle, and Xfer_Count=4.
- Round-robin, NUM_CH=4, Arb_Mode=1, all valid, Write_Ready=1 for 8 cycles. Required: Grant_Ch sequence 0,1,2,3,0,1,2,3, and each Ch_Ready high exactly twice.
- Backpressure: one grant loaded, then Write_Ready=0 for 5 cycles with Ch_Valid=11. Required:
  - Write_Data/Write_Addr stable.
  - Ch_Ready=00.
  - Rr_Ptr unchanged.
  - On Write_Ready=1, the next winner loads at the same edge, and the count increments by 1.
- Counter wrap: preload via 65535 back-to-back writes, then one more. Required: Xfer_Count 0xFFFF -> 0x0000, and Write_Valid unaffected.
- Mode switch: in round-robin, grant channel 2 (NUM_CH=4), switch Arb_Mode=0 with Ch_Valid=1100, then switch back with Ch_Valid=1111. Required: fixed grant = 2, then the round-robin grant = 3, because Rr_Ptr was held at 3.
